// File: rtl/delay_line_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : delay_line_cfg_ctrl
// Description : Sequences glitch-free reconfiguration of a multiplexed clock
//               delay line. A new select code is accepted over a valid/ready
//               handshake. The delayed clock is gated off and the code is
//               applied either as a single jump or one step at a time. After
//               each code change the controller waits for the mux to settle,
//               then re-enables the delayed clock.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i        in   1       free-running reference clock (not the delayed clk)
//   rst_ni       in   1       asynchronous active-low reset
//   req_valid_i  in   1       new delay request valid
//   req_ready_o  out  1       controller idle, request can be accepted
//   req_delay_i  in   DelayW  requested delay code
//   req_ramp_i   in   1       1 = step by +/-1 per update, 0 = single jump
//   delay_o      out  DelayW  select code driven to the delay line
//   gate_en_o    out  1       clock-gate enable after the delay line
//   busy_o       out  1       reconfiguration in progress
//   done_o       out  1       one-cycle pulse when reconfiguration completes
// ============================================================================
module delay_line_cfg_ctrl #(
  parameter int DelayW       = 4,
  parameter int SettleCycles = 4,
  parameter int ResetDelay   = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [DelayW-1:0] req_delay_i,
  input  logic              req_ramp_i,
  output logic [DelayW-1:0] delay_o,
  output logic              gate_en_o,
  output logic              busy_o,
  output logic              done_o
);

  // Counter must hold SettleCycles-1; keep at least one bit so SettleCycles=1
  // still yields a legal vector.
  localparam int CNT_W_RAW = $clog2(SettleCycles + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

  localparam logic [CNT_W-1:0]  CNT_INIT   = CNT_W'(SettleCycles - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [DelayW-1:0] RESET_CODE = DelayW'(ResetDelay);
  localparam logic [DelayW-1:0] CODE_ONE   = DelayW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DelayW-1:0]   target;
  logic                ramp;
  logic [DelayW-1:0]   step_code;
  logic                xfer;

  // Handshake signals are pure state decodes so a request offered in the
  // done_o cycle (already back in IDLE) is accepted without a bubble.
  assign req_ready_o = (state == ST_IDLE);
  assign busy_o      = (state != ST_IDLE);
  assign xfer        = req_valid_i && req_ready_o;

  // Ramp step is always toward target, so it can never wrap past 0 or the
  // top code: UPDATE is only reached while delay_o != target.
  always_comb begin
    step_code = delay_o;
    if (target > delay_o) begin
      step_code = delay_o + CODE_ONE;
    end else begin
      step_code = delay_o - CODE_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      target    <= RESET_CODE;
      ramp      <= 1'b0;
      delay_o   <= RESET_CODE;
      gate_en_o <= 1'b1;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (xfer) begin
            target <= req_delay_i;
            ramp   <= req_ramp_i;
            if (req_delay_i == delay_o) begin
              // Nothing to change: acknowledge without touching the gate.
              done_o <= 1'b1;
            end else begin
              gate_en_o <= 1'b0;
              cnt       <= CNT_INIT;
              state     <= ST_DRAIN;
            end
          end
        end

        // Let in-flight delayed-clock edges drain before the mux moves.
        ST_DRAIN: begin
          if (cnt == '0) begin
            state <= ST_UPDATE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_UPDATE: begin
          if (ramp) begin
            delay_o <= step_code;
          end else begin
            delay_o <= target;
          end
          cnt   <= CNT_INIT;
          state <= ST_SETTLE;
        end

        // Wait for the mux chain to settle on the new code; either take the
        // next ramp step or release the gate.
        ST_SETTLE: begin
          if (cnt == '0) begin
            if (delay_o != target) begin
              state <= ST_UPDATE;
            end else begin
              gate_en_o <= 1'b1;
              done_o    <= 1'b1;
              state     <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_delay_line_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_line_cfg_ctrl
// Description : Self-checking bench for delay_line_cfg_ctrl. Expected outputs
//               come from a timeline model: after a handshake the gate is
//               low for a computed number of cycles, the code moves in steps
//               at fixed cycle offsets, and done pulses right after.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_line_cfg_ctrl;

  localparam int DW  = 4;
  localparam int S   = 4;
  localparam int RD  = 0;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_delay;
  logic          req_ramp;
  logic [DW-1:0] delay;
  logic          gate_en;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int cur_delay = RD;

  delay_line_cfg_ctrl #(
    .DelayW      (DW),
    .SettleCycles(S),
    .ResetDelay  (RD)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_delay_i(req_delay),
    .req_ramp_i (req_ramp),
    .delay_o    (delay),
    .gate_en_o  (gate_en),
    .busy_o     (busy),
    .done_o     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Issue one request at the current negedge and check every output on each
  // cycle until the done cycle. With junk=1 the valid line stays high with
  // random data while busy. With chain=1 the next request (ntgt/nrmp) is
  // presented in the done cycle.
  task automatic run_reconfig(input int tgt, input bit rmp, input bit junk,
                              input bit chain, input int ntgt, input bit nrmp);
    int start, k, len, s, exp_d;
    bit exp_gate, exp_done, exp_busy;
    start     = cur_delay;
    req_valid = 1'b1;
    req_delay = tgt[DW-1:0];
    req_ramp  = rmp;
    @(posedge clk);
    #1;
    if (junk) begin
      req_delay = DW'($urandom_range(0, 15));
      req_ramp  = 1'($urandom_range(0, 1));
    end else begin
      req_valid = 1'b0;
    end
    k = (tgt > start) ? tgt - start : start - tgt;
    if (k == 0)   len = 0;
    else if (rmp) len = S + k * (S + 1);
    else          len = 2 * S + 1;
    for (int n = 1; n <= len + 1; n++) begin
      @(negedge clk);
      // Number of code updates visible by cycle n: first at S+2, then every S+1.
      if (len == 0 || n < S + 2) s = 0;
      else s = (n - (S + 2)) / (S + 1) + 1;
      if (!rmp && s > 1) s = 1;
      if (rmp && s > k) s = k;
      if (!rmp)            exp_d = (s > 0) ? tgt : start;
      else if (tgt > start) exp_d = start + s;
      else                  exp_d = start - s;
      exp_gate = (n > len);
      exp_done = (n == len + 1);
      exp_busy = (n <= len);
      checks += 5;
      if (delay !== exp_d[DW-1:0]) begin
        errors++;
        $display("FAIL delay_o %0d->%0d cyc%0d: got %0d expected %0d", start, tgt, n, delay, exp_d);
      end
      if (gate_en !== exp_gate) begin
        errors++;
        $display("FAIL gate_en_o %0d->%0d cyc%0d: got %b expected %b", start, tgt, n, gate_en, exp_gate);
      end
      if (done !== exp_done) begin
        errors++;
        $display("FAIL done_o %0d->%0d cyc%0d: got %b expected %b", start, tgt, n, done, exp_done);
      end
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy_o %0d->%0d cyc%0d: got %b expected %b", start, tgt, n, busy, exp_busy);
      end
      if (req_ready !== !exp_busy) begin
        errors++;
        $display("FAIL req_ready_o %0d->%0d cyc%0d: got %b expected %b", start, tgt, n, req_ready, !exp_busy);
      end
      if (junk && n <= len) begin
        req_delay = DW'($urandom_range(0, 15));
        req_ramp  = 1'($urandom_range(0, 1));
      end
      if (n == len + 1) begin
        if (chain) begin
          req_valid = 1'b1;
          req_delay = ntgt[DW-1:0];
          req_ramp  = nrmp;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    cur_delay = tgt;
  endtask

  task automatic test_reset();
    req_valid = 1'b0;
    req_delay = '0;
    req_ramp  = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cur_delay = RD;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (delay !== DW'(RD) || gate_en !== 1'b1 || req_ready !== 1'b1 ||
          done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: got delay=%0d gate=%b ready=%b done=%b busy=%b expected delay=%0d gate=1 ready=1 done=0 busy=0",
                 i, delay, gate_en, req_ready, done, busy, RD);
      end
    end
  endtask

  task automatic test_jump();
    run_reconfig(9, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_ramp();
    run_reconfig(6, 1'b1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_same_code();
    run_reconfig(6, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_reconfig(6, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Busy-time requests are ignored; request offered in the done cycle is taken.
  task automatic test_back_to_back();
    run_reconfig(2, 1'b0, 1'b1, 1'b1, 12, 1'b0);
    run_reconfig(12, 1'b0, 1'b1, 1'b1, 10, 1'b1);
    run_reconfig(10, 1'b1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_boundary();
    run_reconfig(15, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_reconfig(0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_reconfig(15, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_reconfig(0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    int t, nt, gap;
    bit r, nr, junk, chain;
    nt = $urandom_range(0, 15);
    nr = 1'($urandom_range(0, 1));
    for (int i = 0; i < 12; i++) begin
      t     = nt;
      r     = nr;
      nt    = $urandom_range(0, 15);
      nr    = 1'($urandom_range(0, 1));
      junk  = 1'($urandom_range(0, 1));
      chain = 1'($urandom_range(0, 1));
      run_reconfig(t, r, junk, chain, nt, nr);
      if (!chain) begin
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          checks++;
          if (delay !== cur_delay[DW-1:0] || gate_en !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_gap: got delay=%0d gate=%b busy=%b done=%b expected delay=%0d gate=1 busy=0 done=0",
                     delay, gate_en, busy, done, cur_delay);
          end
        end
      end
    end
  endtask

  // Reset asserted between clock edges while settling after the first ramp step.
  task automatic test_reset_mid();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cur_delay = RD;
    req_valid = 1'b1;
    req_delay = 4'd15;
    req_ramp  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (S + 3) @(negedge clk);
    checks++;
    if (delay !== 4'd1 || gate_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_settle: got delay=%0d gate=%b busy=%b expected delay=1 gate=0 busy=1",
               delay, gate_en, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (delay !== DW'(RD) || gate_en !== 1'b1 || done !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got delay=%0d gate=%b done=%b ready=%b expected delay=%0d gate=1 done=0 ready=1",
               delay, gate_en, done, req_ready, RD);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (delay !== DW'(RD) || gate_en !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got delay=%0d gate=%b ready=%b busy=%b expected delay=%0d gate=1 ready=1 busy=0",
               delay, gate_en, req_ready, busy, RD);
    end
    run_reconfig(3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_delay = '0;
    req_ramp  = 1'b0;
    test_reset();
    test_jump();
    test_ramp();
    test_same_code();
    test_back_to_back();
    test_boundary();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
